// File: rtl/conditional_logic.sv
// Condition evaluation and write gating: holds NZCV flags, evaluates the
// instruction's condition code against them and gates branch/reg/mem writes.
module conditional_logic (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       MemW,
  input  logic       NoWrite,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       MemWrite
);

  localparam logic [2:0] CondAl = 3'b000;
  localparam logic [2:0] CondEq = 3'b001;
  localparam logic [2:0] CondNe = 3'b010;
  localparam logic [2:0] CondGt = 3'b011;
  localparam logic [2:0] CondGe = 3'b100;
  localparam logic [2:0] CondLt = 3'b101;
  localparam logic [2:0] CondLe = 3'b110;

  logic [1:0] nz_q;
  logic [1:0] cv_q;
  logic [1:0] flag_write;
  logic       flag_n;
  logic       flag_z;
  logic       flag_v;
  logic       cond_ex;

  // C is architectural state only; no defined condition reads it.
  logic       flag_c_unused;

  assign flag_n        = nz_q[1];
  assign flag_z        = nz_q[0];
  assign flag_c_unused = cv_q[1];
  assign flag_v        = cv_q[0];

  always_comb begin
    cond_ex = 1'b0;
    case (Cond)
      CondAl:  cond_ex = 1'b1;
      CondEq:  cond_ex = flag_z;
      CondNe:  cond_ex = ~flag_z;
      CondGt:  cond_ex = ~flag_z & (flag_n == flag_v);
      CondGe:  cond_ex = (flag_n == flag_v);
      CondLt:  cond_ex = (flag_n != flag_v);
      CondLe:  cond_ex = flag_z | (flag_n != flag_v);
      default: cond_ex = 1'b0;
    endcase
  end

  assign flag_write = FlagW & {2{cond_ex}};

  always_ff @(posedge clk) begin
    if (reset) begin
      nz_q <= 2'b00;
      cv_q <= 2'b00;
    end else begin
      if (flag_write[1]) nz_q <= ALUFlags[3:2];
      if (flag_write[0]) cv_q <= ALUFlags[1:0];
    end
  end

  assign PCSrc    = PCS & cond_ex;
  assign RegWrite = RegW & cond_ex & ~NoWrite;
  assign MemWrite = MemW & cond_ex;

endmodule

// File: tb/tb_conditional_logic.sv
// Self-checking bench for conditional_logic: flag model plus per-cycle compare
// and directed literal expectations.
module tb_conditional_logic;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] cond;
  logic [3:0] alu_flags;
  logic [1:0] flag_w;
  logic       pcs;
  logic       reg_w;
  logic       mem_w;
  logic       no_write;
  logic       pc_src;
  logic       reg_write;
  logic       mem_write;

  int compared   = 0;
  int mismatched = 0;

  // Model flags as four separate architectural bits.
  bit m_n = 1'b0;
  bit m_z = 1'b0;
  bit m_c = 1'b0;
  bit m_v = 1'b0;

  conditional_logic dut (
    .clk      (clk),
    .reset    (reset),
    .Cond     (cond),
    .ALUFlags (alu_flags),
    .FlagW    (flag_w),
    .PCS      (pcs),
    .RegW     (reg_w),
    .MemW     (mem_w),
    .NoWrite  (no_write),
    .PCSrc    (pc_src),
    .RegWrite (reg_write),
    .MemWrite (mem_write)
  );

  always #5 clk = ~clk;

  // Signed-compare view: N==V means "greater or equal" after a CMP.
  function automatic bit cond_holds(input logic [2:0] c, input bit n, input bit z,
                                    input bit v);
    bit ge;
    ge = (n == v);
    case (c)
      3'd0:    return 1'b1;
      3'd1:    return z;
      3'd2:    return !z;
      3'd3:    return ge && !z;
      3'd4:    return ge;
      3'd5:    return !ge;
      3'd6:    return z || !ge;
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      {m_n, m_z, m_c, m_v} <= 4'b0000;
    end else if (cond_holds(cond, m_n, m_z, m_v)) begin
      if (flag_w[1]) {m_n, m_z} <= alu_flags[3:2];
      if (flag_w[0]) {m_c, m_v} <= alu_flags[1:0];
    end
  end

  task automatic check(input string name, input logic got, input logic exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the rising edge.
  always @(negedge clk) begin
    bit ok;
    ok = cond_holds(cond, m_n, m_z, m_v);
    check("model_pcsrc",    pc_src,    pcs & ok);
    check("model_regwrite", reg_write, reg_w & ok & !no_write);
    check("model_memwrite", mem_write, mem_w & ok);
  end

  task automatic drive(input logic r, input logic [2:0] c, input logic [3:0] af,
                       input logic [1:0] fw, input logic p, input logic rw,
                       input logic mw, input logic nw);
    @(posedge clk);
    #1;
    reset     = r;
    cond      = c;
    alu_flags = af;
    flag_w    = fw;
    pcs       = p;
    reg_w     = rw;
    mem_w     = mw;
    no_write  = nw;
    #1;
  endtask

  initial begin
    reset = 1'b1; cond = 3'd0; alu_flags = 4'd0; flag_w = 2'd0;
    pcs = 1'b0; reg_w = 1'b0; mem_w = 1'b0; no_write = 1'b0;

    // Reset then idle
    drive(0, 3'b001, 4'h0, 2'b00, 1, 0, 0, 0);
    check("reset_eq_pcsrc", pc_src, 1'b0);
    drive(0, 3'b000, 4'h0, 2'b00, 0, 1, 1, 0);
    check("al_regwrite", reg_write, 1'b1);
    check("al_memwrite", mem_write, 1'b1);

    // CMP then BGT
    drive(0, 3'b000, 4'b0010, 2'b11, 0, 0, 0, 1);
    check("cmp_pcsrc", pc_src, 1'b0);
    check("cmp_regwrite", reg_write, 1'b0);
    check("cmp_memwrite", mem_write, 1'b0);
    drive(0, 3'b011, 4'h0, 2'b00, 1, 0, 0, 0);
    check("bgt_pcsrc", pc_src, 1'b1);
    drive(0, 3'b101, 4'h0, 2'b00, 1, 0, 0, 0);
    check("blt_pcsrc", pc_src, 1'b0);
    drive(0, 3'b110, 4'h0, 2'b00, 1, 0, 0, 0);
    check("ble_pcsrc", pc_src, 1'b0);
    drive(0, 3'b100, 4'h0, 2'b00, 1, 0, 0, 0);
    check("bge_pcsrc", pc_src, 1'b1);

    // Partial flag write from a cleared state
    drive(1, 3'b000, 4'h0, 2'b00, 0, 0, 0, 0);
    drive(0, 3'b000, 4'b1111, 2'b10, 0, 0, 0, 0);
    drive(0, 3'b101, 4'h0, 2'b00, 1, 0, 0, 0);
    check("partial_lt_pcsrc", pc_src, 1'b1);
    drive(0, 3'b001, 4'h0, 2'b00, 1, 0, 0, 0);
    check("partial_eq_pcsrc", pc_src, 1'b1);
    drive(0, 3'b011, 4'h0, 2'b00, 1, 0, 0, 0);
    check("partial_gt_pcsrc", pc_src, 1'b0);

    // Blocked conditional flag write
    drive(0, 3'b000, 4'b0100, 2'b11, 0, 0, 0, 0);
    drive(0, 3'b010, 4'b0000, 2'b11, 1, 1, 1, 0);
    check("blocked_pcsrc", pc_src, 1'b0);
    check("blocked_regwrite", reg_write, 1'b0);
    check("blocked_memwrite", mem_write, 1'b0);
    drive(0, 3'b001, 4'h0, 2'b00, 1, 0, 0, 0);
    check("blocked_flags_kept", pc_src, 1'b1);

    // Reset pulse between edges must not clear flags
    reset = 1'b1;
    #2;
    reset = 1'b0;
    check("async_reset_ignored", pc_src, 1'b1);

    // NoWrite and reset priority
    drive(0, 3'b000, 4'h0, 2'b00, 0, 1, 0, 1);
    check("nowrite_regwrite", reg_write, 1'b0);
    drive(1, 3'b000, 4'b1111, 2'b11, 0, 0, 0, 0);
    drive(0, 3'b001, 4'h0, 2'b00, 1, 0, 0, 0);
    check("reset_prio_eq", pc_src, 1'b0);
    drive(0, 3'b100, 4'h0, 2'b00, 1, 0, 0, 0);
    check("reset_prio_ge", pc_src, 1'b1);
    drive(0, 3'b110, 4'h0, 2'b00, 1, 0, 0, 0);
    check("reset_prio_le", pc_src, 1'b0);
    drive(0, 3'b111, 4'h0, 2'b00, 1, 1, 1, 0);
    check("nv_pcsrc", pc_src, 1'b0);

    // Mixed traffic checked by the model each cycle
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 19) == 0), 3'($urandom), 4'($urandom), 2'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
